// File: rtl/decoder_rr_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
// Contents: state_t (IDLE/GRANT), NREQ (requester count), IDXW (index width),
//           rr_pick() round-robin winner search.
package decoder_rr_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {found, index} of the first set req bit, scanning ptr, ptr+1, ...
  // modulo NREQ. The scan runs from the farthest offset down so the nearest
  // requester is the last one written and therefore wins.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IDXW-1:0] ptr);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] cand;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + IDXW'(i);
      if (req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot_dec_3_8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
// Latency: combinational.
// Backpressure: none.
// Ports: idx  - binary index in
//        en   - decode enable
//        onehot - 8-bit one-hot (or zero) out
module onehot_dec_3_8
  import decoder_rr_pkg::*;
(
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [NREQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 level-sensitive requesters with bounded grant hold.
// Latency: grant registered 1 cycle after the winning request is sampled.
// Backpressure: requester keeps req high to hold; released on req drop or HOLD_MAX.
// Ports: clk, rst (async, active-high)
//        En      - enable for issuing new grants (never revokes a live grant)
//        req     - per-requester request bits
//        gnt     - registered one-hot grant; gnt_idx/gnt_vld - its index / valid
module decoder_rr_arbiter
  import decoder_rr_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            En,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t          state_q, state_n;
  logic [IDXW-1:0] ptr_q, ptr_n;
  logic [3:0]      cnt_q, cnt_n;
  logic [IDXW-1:0] idx_q, idx_n;
  logic            vld_q, vld_n;
  logic [NREQ-1:0] gnt_q, gnt_n;

  logic            rel;
  logic [IDXW-1:0] search_ptr;
  logic [IDXW:0]   pick;

  // Release frees the current owner; searching from owner+1 in the same cycle
  // lets the grant hand over without an idle bubble and puts the old owner last.
  assign rel        = (state_q == GRANT) && (!req[idx_q] || (cnt_q == HOLD_LIM));
  assign search_ptr = rel ? idx_q + IDXW'(1) : ptr_q;
  assign pick       = rr_pick(req, search_ptr);

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    vld_n   = vld_q;
    case (state_q)
      IDLE: begin
        if (En && pick[IDXW]) begin
          state_n = GRANT;
          idx_n   = pick[IDXW-1:0];
          vld_n   = 1'b1;
          cnt_n   = 4'd1;
        end else begin
          state_n = IDLE;
          idx_n   = '0;
          vld_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_n = search_ptr;
          if (En && pick[IDXW]) begin
            state_n = GRANT;
            idx_n   = pick[IDXW-1:0];
            vld_n   = 1'b1;
            cnt_n   = 4'd1;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
            vld_n   = 1'b0;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt_q + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        vld_n   = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  // Decode the next index so gnt is a plain register alongside gnt_idx/gnt_vld.
  onehot_dec_3_8 u_dec (
    .idx    (idx_n),
    .en     (vld_n),
    .onehot (gnt_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      vld_q   <= vld_n;
      gnt_q   <= gnt_n;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

endmodule
